// File: rtl/reg_bank.sv
// reg_bank: DEPTH x WIDTH register bank for the processor datapath.
//   One write port that executes an in-place op on the addressed register:
//   LOAD, INC, DEC or SHL. It also updates the carry and zero status flags.
//   Two read ports each have their own enable and give registered outputs.
//   A write to the address being read in the same cycle is bypassed, so the
//   read returns the new value.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   wr_en, wr_addr, wr_op  write strobe, target register, op (00 LD 01 INC 10 DEC 11 SHL)
//   wr_data                LOAD operand
//   rd_en_a/b, rd_addr_a/b read enables and addresses (enable low holds the output)
//   rd_data_a/b            registered read data
//   flag_c, flag_z         carry/borrow/shift-out and zero of the last executed write
module reg_bank #(
  parameter int  WIDTH = 8,
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [1:0]       wr_op,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en_a,
  input  logic [AW-1:0]    rd_addr_a,
  output logic [WIDTH-1:0] rd_data_a,
  input  logic             rd_en_b,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             flag_c,
  output logic             flag_z
);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_DEC  = 2'b10;
  localparam logic [1:0] OP_SHL  = 2'b11;

  // Returns {carry, result} for one write op applied to old value v.
  function automatic logic [WIDTH:0] exec_op(
    input logic [1:0]       op,
    input logic [WIDTH-1:0] v,
    input logic [WIDTH-1:0] d
  );
    logic [WIDTH:0] res;
    case (op)
      OP_LOAD: res = {1'b0, d};
      // Extending to WIDTH+1 bits makes the top bit the carry out.
      OP_INC:  res = {1'b0, v} + (WIDTH+1)'(1);
      // A borrow happens only when decrementing zero.
      OP_DEC:  res = {(v == {WIDTH{1'b0}}), v - WIDTH'(1)};
      OP_SHL:  res = {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
      default: res = {1'b0, v};
    endcase
    return res;
  endfunction

  logic [WIDTH-1:0] bank_r [DEPTH];
  logic [WIDTH-1:0] old_s;
  logic [WIDTH-1:0] result_s;
  logic             carry_s;

  // Compute the write result from the addressed register's current value.
  always_comb begin
    old_s               = bank_r[wr_addr];
    {carry_s, result_s} = exec_op(wr_op, old_s, wr_data);
  end

  // Register bank storage and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        bank_r[i] <= {WIDTH{1'b0}};
      end
      flag_c <= 1'b0;
      flag_z <= 1'b0;
    end else if (wr_en) begin
      bank_r[wr_addr] <= result_s;
      flag_c          <= carry_s;
      flag_z          <= (result_s == {WIDTH{1'b0}});
    end else begin
      flag_c <= flag_c;
      flag_z <= flag_z;
    end
  end

  // Read port A: registered, with write-first bypass on an address match.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_a <= {WIDTH{1'b0}};
    end else if (rd_en_a) begin
      if (wr_en && (rd_addr_a == wr_addr)) begin
        rd_data_a <= result_s;
      end else begin
        rd_data_a <= bank_r[rd_addr_a];
      end
    end else begin
      rd_data_a <= rd_data_a;
    end
  end

  // Read port B: same behaviour as port A, independent address and enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_b <= {WIDTH{1'b0}};
    end else if (rd_en_b) begin
      if (wr_en && (rd_addr_b == wr_addr)) begin
        rd_data_b <= result_s;
      end else begin
        rd_data_b <= bank_r[rd_addr_b];
      end
    end else begin
      rd_data_b <= rd_data_b;
    end
  end

endmodule

// File: tb/tb_reg_bank.sv
// Directed testbench for reg_bank (WIDTH=8, DEPTH=4).
module tb_reg_bank;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic             clk;
  logic             rst_n;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [1:0]       wr_op;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en_a;
  logic [AW-1:0]    rd_addr_a;
  logic [WIDTH-1:0] rd_data_a;
  logic             rd_en_b;
  logic [AW-1:0]    rd_addr_b;
  logic [WIDTH-1:0] rd_data_b;
  logic             flag_c;
  logic             flag_z;

  int tests_run    = 0;
  int tests_failed = 0;

  reg_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_op     (wr_op),
    .wr_data   (wr_data),
    .rd_en_a   (rd_en_a),
    .rd_addr_a (rd_addr_a),
    .rd_data_a (rd_data_a),
    .rd_en_b   (rd_en_b),
    .rd_addr_b (rd_addr_b),
    .rd_data_b (rd_data_b),
    .flag_c    (flag_c),
    .flag_z    (flag_z)
  );

  // 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input logic en, input logic [AW-1:0] a, input logic [1:0] op,
                        input logic [WIDTH-1:0] d);
    wr_en   = en;
    wr_addr = a;
    wr_op   = op;
    wr_data = d;
  endtask

  initial begin
    rst_n = 1'b0;
    set_wr(1'b0, 2'd0, 2'b00, 8'h00);
    rd_en_a = 1'b0; rd_addr_a = 2'd0;
    rd_en_b = 1'b0; rd_addr_b = 2'd0;
    #2;
    check("reset_rd_a", rd_data_a, 8'h00);
    check("reset_rd_b", rd_data_b, 8'h00);
    check("reset_c", flag_c, 1'b0);
    check("reset_z", flag_z, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // LOAD r2 = 3C, then read it back on port A.
    set_wr(1'b1, 2'd2, 2'b00, 8'h3C);
    step();
    check("load_c", flag_c, 1'b0);
    check("load_z", flag_z, 1'b0);
    set_wr(1'b0, 2'd0, 2'b00, 8'h00);
    rd_en_a = 1'b1; rd_addr_a = 2'd2;
    step();
    check("load_rd_a", rd_data_a, 8'h3C);
    rd_en_a = 1'b0;

    // Wrap: LOAD r0 = FF, INC -> 00 c1 z1, DEC -> FF c1 z0.
    set_wr(1'b1, 2'd0, 2'b00, 8'hFF);
    step();
    check("loadff_z", flag_z, 1'b0);
    set_wr(1'b1, 2'd0, 2'b01, 8'h00);
    step();
    check("inc_wrap_c", flag_c, 1'b1);
    check("inc_wrap_z", flag_z, 1'b1);
    set_wr(1'b1, 2'd0, 2'b10, 8'h00);
    step();
    check("dec_wrap_c", flag_c, 1'b1);
    check("dec_wrap_z", flag_z, 1'b0);
    set_wr(1'b0, 2'd0, 2'b00, 8'h00);
    rd_en_a = 1'b1; rd_addr_a = 2'd0;
    step();
    check("dec_wrap_rd", rd_data_a, 8'hFF);
    check("hold_c", flag_c, 1'b1);
    check("hold_z", flag_z, 1'b0);
    rd_en_a = 1'b0;

    // SHL: LOAD r3 = 81, SHL -> 02 c1, SHL -> 04 c0, DEC -> 03 c0.
    set_wr(1'b1, 2'd3, 2'b00, 8'h81);
    step();
    set_wr(1'b1, 2'd3, 2'b11, 8'h00);
    step();
    check("shl1_c", flag_c, 1'b1);
    check("shl1_z", flag_z, 1'b0);
    rd_en_b = 1'b1; rd_addr_b = 2'd3;
    step();
    check("shl2_c", flag_c, 1'b0);
    check("shl2_rd_b", rd_data_b, 8'h04);
    set_wr(1'b1, 2'd3, 2'b10, 8'h00);
    rd_en_b = 1'b0;
    step();
    check("dec_c", flag_c, 1'b0);
    check("dec_z", flag_z, 1'b0);

    // Bypass: LOAD r1 = 55 while both ports read r1.
    set_wr(1'b1, 2'd1, 2'b00, 8'h55);
    rd_en_a = 1'b1; rd_addr_a = 2'd1;
    rd_en_b = 1'b1; rd_addr_b = 2'd1;
    step();
    check("bypass_a", rd_data_a, 8'h55);
    check("bypass_b", rd_data_b, 8'h55);

    // Hold: ports disabled while r1 is overwritten.
    rd_en_a = 1'b0; rd_en_b = 1'b0;
    set_wr(1'b1, 2'd1, 2'b00, 8'hAA);
    step();
    check("hold_b1", rd_data_b, 8'h55);
    set_wr(1'b0, 2'd0, 2'b00, 8'h00);
    step();
    check("hold_b2", rd_data_b, 8'h55);
    check("hold_a", rd_data_a, 8'h55);
    rd_en_b = 1'b1;
    step();
    check("hold_release_b", rd_data_b, 8'hAA);

    // Independent ports at different addresses.
    rd_en_a = 1'b1; rd_addr_a = 2'd2;
    rd_en_b = 1'b1; rd_addr_b = 2'd3;
    step();
    check("indep_a", rd_data_a, 8'h3C);
    check("indep_b", rd_data_b, 8'h03);

    // Asynchronous reset mid-cycle with non-zero outputs and flags.
    set_wr(1'b1, 2'd1, 2'b00, 8'hA5);
    rd_en_a = 1'b0; rd_en_b = 1'b0;
    step();
    set_wr(1'b1, 2'd3, 2'b00, 8'h00);
    rd_en_a = 1'b1; rd_addr_a = 2'd1;
    rd_en_b = 1'b1; rd_addr_b = 2'd2;
    step();
    check("pre_rst_a", rd_data_a, 8'hA5);
    check("pre_rst_b", rd_data_b, 8'h3C);
    check("pre_rst_z", flag_z, 1'b1);
    set_wr(1'b1, 2'd0, 2'b01, 8'h00);
    step();
    check("pre_rst_c", flag_c, 1'b1);
    set_wr(1'b0, 2'd0, 2'b00, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_a", rd_data_a, 8'h00);
    check("async_rst_b", rd_data_b, 8'h00);
    check("async_rst_c", flag_c, 1'b0);
    check("async_rst_z", flag_z, 1'b0);
    #2;
    rst_n = 1'b1;
    rd_addr_a = 2'd1;
    rd_addr_b = 2'd2;
    step();
    check("post_rst_r1", rd_data_a, 8'h00);
    check("post_rst_r2", rd_data_b, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
